// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, load extraction with a stall-safe
// hold of the data-memory output, register-file write port and retire counter.
module wb_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [XLEN-1:0]  in_aluresult,
    input  logic [4:0]       in_rd,
    input  logic [XLEN-1:0]  in_pcplus4,
    input  logic             in_regwrite,
    input  logic [1:0]       in_resultsrc,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  readdata,
    output logic             rd_we,
    output logic [4:0]       rd_addr,
    output logic [XLEN-1:0]  rd_wdata,
    output logic [CNT_W-1:0] retired,
    output logic             misalign_err
);

    logic             valid_q;
    logic [XLEN-1:0]  aluresult_q;
    logic [4:0]       rd_q;
    logic [XLEN-1:0]  pcplus4_q;
    logic             regwrite_q;
    logic [1:0]       resultsrc_q;
    logic [2:0]       funct3_q;

    logic             hold_vld_q;
    logic [XLEN-1:0]  hold_data_q;
    logic [CNT_W-1:0] retired_q;
    logic             misalign_q;

    logic [XLEN-1:0]  ld_raw;
    logic [1:0]       offset;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [XLEN-1:0]  ld_ext;
    logic             size_mis;
    logic             misaligned;

    // MEM/WB register: reset, then flush (bubble), then stall (hold), else load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            aluresult_q <= '0;
            rd_q        <= '0;
            pcplus4_q   <= '0;
            regwrite_q  <= 1'b0;
            resultsrc_q <= '0;
            funct3_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            valid_q     <= in_valid;
            aluresult_q <= in_aluresult;
            rd_q        <= in_rd;
            pcplus4_q   <= in_pcplus4;
            regwrite_q  <= in_regwrite;
            resultsrc_q <= in_resultsrc;
            funct3_q    <= in_funct3;
        end
    end

    // Capture memory data on the first stalled edge; the memory output may move afterwards
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
        end else if (stall) begin
            if (!hold_vld_q) begin
                hold_vld_q  <= 1'b1;
                hold_data_q <= readdata;
            end
        end else begin
            hold_vld_q <= 1'b0;
        end
    end

    // Retire counter and sticky misaligned-load flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            if (valid_q && !stall) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            if (valid_q && misaligned) begin
                misalign_q <= 1'b1;
            end
        end
    end

    // Little-endian load extraction and alignment check
    always_comb begin
        ld_raw  = hold_vld_q ? hold_data_q : readdata;
        offset  = aluresult_q[1:0];
        ld_byte = ld_raw[7:0];
        unique case (offset)
            2'b00: ld_byte = ld_raw[7:0];
            2'b01: ld_byte = ld_raw[15:8];
            2'b10: ld_byte = ld_raw[23:16];
            2'b11: ld_byte = ld_raw[31:24];
        endcase
        ld_half  = offset[1] ? ld_raw[31:16] : ld_raw[15:0];
        ld_ext   = ld_raw;
        size_mis = 1'b0;
        unique case (funct3_q)
            3'b000: ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001: begin
                ld_ext   = {{(XLEN-16){ld_half[15]}}, ld_half};
                size_mis = offset[0];
            end
            3'b100: ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101: begin
                ld_ext   = {{(XLEN-16){1'b0}}, ld_half};
                size_mis = offset[0];
            end
            default: begin
                ld_ext   = ld_raw;
                size_mis = (offset != 2'b00);
            end
        endcase
        misaligned = (resultsrc_q == 2'b01) && size_mis;
    end

    // Register-file write port; rd_wdata doubles as the WB forwarding value
    always_comb begin
        rd_wdata = aluresult_q;
        unique case (resultsrc_q)
            2'b01:   rd_wdata = ld_ext;
            2'b10:   rd_wdata = pcplus4_q;
            default: rd_wdata = aluresult_q;
        endcase
        rd_we   = valid_q && regwrite_q && (rd_q != 5'd0) && !misaligned;
        rd_addr = rd_q;
    end

    assign retired      = retired_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a driver issues instructions and pushes the
// expected register write; a monitor pops whenever the retire counter advances.
module tb_wb_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall, flush, in_valid, in_regwrite;
    logic [XLEN-1:0]  in_aluresult, in_pcplus4, readdata;
    logic [4:0]       in_rd;
    logic [1:0]       in_resultsrc;
    logic [2:0]       in_funct3;
    logic             rd_we;
    logic [4:0]       rd_addr;
    logic [XLEN-1:0]  rd_wdata;
    logic [CNT_W-1:0] retired;
    logic             misalign_err;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_aluresult(in_aluresult), .in_rd(in_rd), .in_pcplus4(in_pcplus4),
        .in_regwrite(in_regwrite), .in_resultsrc(in_resultsrc), .in_funct3(in_funct3),
        .readdata(readdata), .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .retired(retired), .misalign_err(misalign_err)
    );

    typedef struct {
        logic        vld;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic        rw;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic [31:0] ldata;  // what the data memory returns for this instruction
    } ins_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb_q[$];
    logic        wb_has = 1'b0;   // a real instruction currently sits in WB
    logic        wb_mis = 1'b0;
    logic        sticky = 1'b0;
    int unsigned exp_retired = 0;
    int unsigned n_real = 0;
    int unsigned n_disc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ins_t mk(input logic [31:0] alu, input logic [4:0] rd,
                                input logic [1:0] rs, input logic [2:0] f3,
                                input logic [31:0] ldata, input logic [31:0] pc4);
        ins_t i;
        i.vld = 1'b1; i.alu = alu; i.rd = rd; i.pc4 = pc4; i.rw = 1'b1;
        i.rs = rs; i.f3 = f3; i.ldata = ldata;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        i.vld   = ($urandom_range(0, 9) != 0);
        i.alu   = $urandom;
        i.rd    = 5'($urandom_range(0, 31));
        i.pc4   = $urandom & 32'hFFFF_FFFC;
        i.rw    = ($urandom_range(0, 3) != 0);
        i.rs    = 2'($urandom_range(0, 3));
        i.f3    = 3'($urandom_range(0, 7));
        i.ldata = $urandom;
        return i;
    endfunction

    function automatic ins_t bubble();
        ins_t i;
        i = rand_ins();
        i.vld = 1'b0;
        return i;
    endfunction

    // Access size in bytes for the load encodings
    function automatic int ld_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] load_val(input ins_t i);
        logic [31:0] w;
        logic [31:0] h;
        w = i.ldata >> (8 * int'(i.alu[1:0]));
        h = i.ldata >> (i.alu[1] ? 16 : 0);
        case (i.f3)
            3'd0:    return 32'($signed(w[7:0]));
            3'd1:    return 32'($signed(h[15:0]));
            3'd4:    return 32'(w[7:0]);
            3'd5:    return 32'(h[15:0]);
            default: return i.ldata;
        endcase
    endfunction

    function automatic exp_t model(input ins_t i);
        exp_t e;
        e.mis  = (i.rs == 2'b01) && ((int'(i.alu[1:0]) % ld_size(i.f3)) != 0);
        e.addr = i.rd;
        case (i.rs)
            2'b01:   e.data = load_val(i);
            2'b10:   e.data = i.pc4;
            default: e.data = i.alu;
        endcase
        e.we = i.rw && (i.rd != 5'd0) && !e.mis;
        return e;
    endfunction

    // One clock: drive inputs, take the edge, update the model, present memory data
    task automatic step(input logic st, input logic fl, input ins_t i, input logic [31:0] junk);
        exp_t e;
        stall = st; flush = fl;
        in_valid = i.vld; in_aluresult = i.alu; in_rd = i.rd; in_pcplus4 = i.pc4;
        in_regwrite = i.rw; in_resultsrc = i.rs; in_funct3 = i.f3;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            sb_q.delete();
            wb_has = 1'b0; wb_mis = 1'b0; sticky = 1'b0;
            exp_retired = 0; n_real = 0; n_disc = 0;
        end else begin
            if (wb_has && wb_mis) sticky = 1'b1;
            if (wb_has && !st) exp_retired++;
            if (wb_has && st && fl) begin
                void'(sb_q.pop_back());
                n_disc++;
            end
            if (fl) begin
                wb_has = 1'b0;
            end else if (!st) begin
                wb_has = i.vld;
                if (i.vld) begin
                    e = model(i);
                    sb_q.push_back(e);
                    wb_mis = e.mis;
                    n_real++;
                end
            end
        end
        readdata = (!st && !fl) ? i.ldata : junk;
        chk("retired", retired, exp_retired);
        chk("misalign_err", 32'(misalign_err), 32'(sticky));
        if (!wb_has) chk("bubble_we", 32'(rd_we), 32'd0);
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_ins(), $urandom);
        rst_n = 1'b1;
    endtask

    // Monitor: when retired advances, the previous cycle's outputs were the retiring write
    initial begin
        logic        prev_ok;
        logic [31:0] prev_ret, delta, p_data;
        logic        p_we;
        logic [4:0]  p_addr;
        exp_t        e;
        prev_ok = 1'b0;
        prev_ret = '0; p_we = 1'b0; p_addr = '0; p_data = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_ok = 1'b0;
            end else begin
                if (prev_ok) begin
                    delta = retired - prev_ret;
                    if (delta == 32'd1) begin
                        if (sb_q.size() == 0) begin
                            chk("sb_nonempty", 32'(sb_q.size()), 32'd1);
                        end else begin
                            e = sb_q.pop_front();
                            chk("wb_we", 32'(p_we), 32'(e.we));
                            chk("wb_addr", 32'(p_addr), 32'(e.addr));
                            chk("wb_data", p_data, e.data);
                        end
                    end else if (delta != 32'd0) begin
                        chk("retired_step", delta, 32'd1);
                    end
                end
                prev_ret = retired; p_we = rd_we; p_addr = rd_addr; p_data = rd_data_snap();
                prev_ok = 1'b1;
            end
        end
    end

    function automatic logic [31:0] rd_data_snap();
        return rd_wdata;
    endfunction

    initial begin
        logic [31:0] r0;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; readdata = '0;

        // Reset with random inputs
        do_reset();
        settle();
        chk("reset_we", 32'(rd_we), 32'd0);
        chk("reset_addr", 32'(rd_addr), 32'd0);
        chk("reset_wdata", rd_wdata, 32'd0);
        chk("reset_retired", retired, 32'd0);
        chk("reset_misalign", 32'(misalign_err), 32'd0);

        // ALU writeback, then the same with rd=0
        step(0, 0, mk(32'h1234_5678, 5'd5, 2'b00, 3'd0, 32'h0, 32'h0), 32'h0);
        settle();
        chk("alu_we", 32'(rd_we), 32'd1);
        chk("alu_addr", 32'(rd_addr), 32'd5);
        chk("alu_wdata", rd_wdata, 32'h1234_5678);
        step(0, 0, mk(32'h1234_5678, 5'd0, 2'b00, 3'd0, 32'h0, 32'h0), 32'h0);
        settle();
        chk("alu_rd0_we", 32'(rd_we), 32'd0);

        // Load extraction from 0x8070_F0A5
        step(0, 0, mk(32'h1001, 5'd2, 2'b01, 3'd0, 32'h8070_F0A5, 32'h0), 32'h0);
        settle(); chk("lb_01", rd_wdata, 32'hFFFF_FFF0);
        step(0, 0, mk(32'h1003, 5'd2, 2'b01, 3'd4, 32'h8070_F0A5, 32'h0), 32'h0);
        settle(); chk("lbu_11", rd_wdata, 32'h0000_0080);
        step(0, 0, mk(32'h1002, 5'd2, 2'b01, 3'd1, 32'h8070_F0A5, 32'h0), 32'h0);
        settle(); chk("lh_10", rd_wdata, 32'hFFFF_8070);
        step(0, 0, mk(32'h1000, 5'd2, 2'b01, 3'd5, 32'h8070_F0A5, 32'h0), 32'h0);
        settle(); chk("lhu_00", rd_wdata, 32'h0000_F0A5);
        step(0, 0, mk(32'h1000, 5'd2, 2'b01, 3'd2, 32'h8070_F0A5, 32'h0), 32'h0);
        settle(); chk("lw", rd_wdata, 32'h8070_F0A5);
        chk("lw_we", 32'(rd_we), 32'd1);

        // Stall hold: memory output drops to zero after the first stalled cycle
        step(0, 0, mk(32'h2000, 5'd7, 2'b01, 3'd2, 32'hDEAD_BEEF, 32'h0), 32'h0);
        settle();
        r0 = retired;
        for (int k = 0; k < 3; k++) begin
            step(1, 0, bubble(), 32'h0);
            settle();
            chk("stall_wdata", rd_wdata, 32'hDEAD_BEEF);
            chk("stall_we", 32'(rd_we), 32'd1);
            chk("stall_retired", retired, r0);
        end
        step(0, 0, bubble(), $urandom);
        settle();
        chk("release_retired", retired, r0 + 32'd1);

        // JAL writes PC+4
        step(0, 0, mk(32'h0, 5'd1, 2'b10, 3'd0, $urandom, 32'h104), $urandom);
        settle();
        chk("jal_wdata", rd_wdata, 32'h104);
        chk("jal_addr", 32'(rd_addr), 32'd1);

        // Flush and stall together: bubble loads, WB instruction does not retire
        step(0, 0, mk(32'h55, 5'd3, 2'b00, 3'd0, 32'h0, 32'h0), $urandom);
        settle();
        r0 = retired;
        step(1, 1, rand_ins(), $urandom);
        settle();
        chk("flush_stall_we", 32'(rd_we), 32'd0);
        chk("flush_stall_retired", retired, r0);
        step(0, 0, bubble(), $urandom);

        // Misaligned lw: no write, sticky flag through further instructions
        step(0, 0, mk(32'h0000_0102, 5'd4, 2'b01, 3'd2, 32'hCAFE_F00D, 32'h0), $urandom);
        settle();
        chk("mis_we", 32'(rd_we), 32'd0);
        for (int k = 0; k < 10; k++) begin
            step(0, 0, mk($urandom & 32'hFFFF_FFFC, 5'($urandom_range(1, 31)), 2'b00, 3'd0,
                          $urandom, 32'h0), $urandom);
            settle();
            chk("mis_sticky", 32'(misalign_err), 32'd1);
        end

        // Drain and compare retire count against issued real instructions
        repeat (2) step(0, 0, bubble(), $urandom);
        @(negedge clk);
        #1;
        chk("retired_total", retired, n_real - n_disc);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        // Reset in the middle of a stalled load discards the held data
        step(0, 0, mk(32'h3000, 5'd9, 2'b01, 3'd2, 32'hAAAA_5555, 32'h0), $urandom);
        step(1, 0, bubble(), $urandom);
        rst_n = 1'b0;
        step(1, 0, bubble(), $urandom);
        rst_n = 1'b1;
        settle();
        chk("midstall_rst_wdata", rd_wdata, 32'd0);
        chk("midstall_rst_we", 32'(rd_we), 32'd0);
        chk("midstall_rst_err", 32'(misalign_err), 32'd0);

        // Randomized traffic with periodic resets
        for (int c = 0; c < 800; c++) begin
            if (c % 200 == 199) do_reset();
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0), rand_ins(),
                 $urandom);
        end

        repeat (3) step(0, 0, bubble(), $urandom);
        @(negedge clk);
        #1;
        chk("final_retired_total", retired, n_real - n_disc);
        chk("final_sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the 5-stage RV32I core: holds the MEM/WB pipeline register, sign/zero-extends load data from the synchronous data memory, selects the register-file write value, and drives the register-file write port. It also serves as the WB-to-EX forwarding source. It sits directly downstream of the memory stage and consumes its pass-through fields plus the data-memory read port output.

## Interface
- XLEN, 32, datapath width
- CNT_W, 32, width of retired-instruction counter

- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- stall  input  1  hold the MEM/WB register contents
- flush  input  1  load a bubble instead of the incoming instruction
- in_valid  input  1  incoming instruction is real
- in_aluresult  input  XLEN  ALU result / memory address
- in_rd  input  5  destination register
- in_pcplus4  input  XLEN  PC+4 for JAL/JALR
- in_regwrite  input  1  instruction writes rd
- in_resultsrc  input  2  00 ALU, 01 load, 10 PC+4, 11 ALU
- in_funct3  input  3  load type
- readdata  input  XLEN  data-memory output, valid one cycle after the address is presented
- rd_we  output  1  register-file write enable
- rd_addr  output  5  register-file write address
- rd_wdata  output  XLEN  register-file write data (also forwarding value)
- retired  output  CNT_W  count of instructions leaving WB
- misalign_err  output  1  sticky misaligned-load flag

## Operation
- WB register fields: valid, aluresult, rd, pcplus4, regwrite, resultsrc, funct3.
- Update priority per edge: reset, then flush (valid<=0, other fields don't-care), then stall (hold), else load all in_* fields.
- Load data source: ld_raw = hold_vld ? hold_data : readdata.
- Hold register: at an edge with stall=1 and hold_vld=0, capture readdata and set hold_vld; at an edge with stall=0, clear hold_vld. Reset clears both.
- Load extraction, little-endian, offset = aluresult[1:0]:
  - 000 lb: sign-extend byte at offset.
  - 001 lh: sign-extend halfword at offset[1].
  - 100 lbu and 101 lhu: as lb/lh, zero-extended.
  - 010 lw and all other codes: full word.
- Misaligned: resultsrc=01 and either (lh/lhu with offset[0]=1) or (lw/other with offset!=00).
- rd_wdata: resultsrc 01 gives the extracted load, 10 gives pcplus4, 00/11 give aluresult.
- rd_we = valid & regwrite & (rd!=0) & !misaligned. Combinational from the WB register.
- rd_addr = rd from the WB register.
- misalign_err: set at the edge where valid & misaligned; cleared only by reset.
- retired: increments at each edge with valid=1 and stall=0. It wraps at 2^CNT_W. It counts misaligned loads.

## Timing
- Latency: in_* sampled at edge N; rd_we/rd_addr/rd_wdata valid during cycle N to N+1. The register file writes at edge N+1.
- Reset values: valid 0, all fields 0, hold_vld 0, retired 0, misalign_err 0.
- With reset values, the outputs are rd_we 0, rd_addr 0, rd_wdata 0.
- During stall, outputs stay constant and rd_we stays asserted. The repeated write is idempotent.
- Load data stays stable across stall even if readdata changes after the first stall cycle.
- flush and stall together: flush wins. The bubble loads, and the current WB instruction counts as retired only if stall=0.
- Flush affects only the incoming slot. The instruction already in WB completes.
- Reset mid-stall: all state clears at that edge, and hold data is discarded.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with random inputs. Required: rd_we=0, rd_wdata=0, retired=0, misalign_err=0.
- ALU writeback: rd=5, aluresult=0x1234_5678, resultsrc=00, regwrite=1. Required, one cycle later: rd_we=1, rd_addr=5, rd_wdata=0x1234_5678. Repeat with rd=0: rd_we=0.
- Load extraction: readdata=0x8070_F0A5.
  - lb, addr ...01: 0xFFFF_FFF0.
  - lbu, addr ...11: 0x0000_0080.
  - lh, addr ...10: 0xFFFF_8070.
  - lhu, addr ...00: 0x0000_F0A5.
  - lw: 0x8070_F0A5.
- Stall hold: load lw with readdata=0xDEAD_BEEF. Assert stall 3 cycles, changing readdata to 0x0 after the first. Required: rd_wdata stays 0xDEAD_BEEF, and retired increments only once, at the release edge.
- Misaligned: lw at addr 0x...02. Required: rd_we=0, misalign_err=1 from the next cycle, and it stays set through 10 further valid instructions until reset.
- Flush+stall and JAL:
  - Flush and stall asserted together: the next cycle shows valid=0, rd_we=0.
  - JAL, resultsrc=10, pcplus4=0x104, rd=1: rd_wdata=0x104.
  - Retired count matches the number of non-bubble instructions issued.
